// File: rtl/remote_comm_if.sv
// rtl/remote_comm_if.sv - host-side command/response signals of the remote link
interface remote_comm_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic [7:0]  resp;
    logic        resp_rdy;

    modport master (output cmd, snd_cmd, input cmd_snt, resp, resp_rdy);
    modport slave  (input cmd, snd_cmd, output cmd_snt, resp, resp_rdy);
endinterface

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - UART 16-bit command transmitter (two 8N1 frames) and response receiver
module remote_comm #(
    parameter int BAUD_CNT = 2604
) (
    input  logic          clk,
    input  logic          rst,
    remote_comm_if.slave  host,
    output logic          TX,
    input  logic          RX
);
    localparam int CW = ($clog2(BAUD_CNT + 1) > 12) ? $clog2(BAUD_CNT + 1) : 12;
    localparam logic [CW-1:0] BAUD_M1 = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_CNT / 2 - 1);

    typedef enum logic [1:0] {C_IDLE, C_SEND_HI, C_SEND_LO} cmd_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    cmd_state_t    cstate;
    logic [9:0]    tx_shift;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bits;
    logic [7:0]    lo_byte;
    logic          tx_q;
    logic          cmd_snt_q;
    logic          accept;

    rx_state_t     rstate;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic [7:0]    resp_q;
    logic          rdy_q;

    assign accept        = (cstate == C_IDLE) && host.snd_cmd;
    assign TX            = tx_q;
    assign host.cmd_snt  = cmd_snt_q;
    assign host.resp     = resp_q;
    assign host.resp_rdy = rdy_q;

    // tx_shift holds {stop, data, start}; tx_q always mirrors the bit currently on the wire
    always_ff @(posedge clk) begin
        if (rst) begin
            cstate    <= C_IDLE;
            tx_shift  <= '1;
            tx_baud   <= '0;
            tx_bits   <= '0;
            lo_byte   <= '0;
            tx_q      <= 1'b1;
            cmd_snt_q <= 1'b0;
        end else begin
            case (cstate)
                C_IDLE: begin
                    if (host.snd_cmd) begin
                        lo_byte   <= host.cmd[7:0];
                        cmd_snt_q <= 1'b0;
                        tx_shift  <= {1'b1, host.cmd[15:8], 1'b0};
                        tx_q      <= 1'b0;
                        tx_baud   <= BAUD_M1;
                        tx_bits   <= '0;
                        cstate    <= C_SEND_HI;
                    end
                end
                default: begin
                    if (tx_baud != '0) begin
                        tx_baud <= tx_baud - 1'b1;
                    end else begin
                        tx_baud <= BAUD_M1;
                        if (tx_bits == 4'd9) begin
                            // Stop bit finished: chain the low byte with no idle gap
                            if (cstate == C_SEND_HI) begin
                                tx_shift <= {1'b1, lo_byte, 1'b0};
                                tx_q     <= 1'b0;
                                tx_bits  <= '0;
                                cstate   <= C_SEND_LO;
                            end else begin
                                cmd_snt_q <= 1'b1;
                                tx_q      <= 1'b1;
                                cstate    <= C_IDLE;
                            end
                        end else begin
                            tx_shift <= {1'b1, tx_shift[9:1]};
                            tx_q     <= tx_shift[1];
                            tx_bits  <= tx_bits + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Later assignments to rdy_q win, so a completed byte overrides any clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate   <= R_IDLE;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_baud  <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            resp_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            if (accept) rdy_q <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (!rx_sync) begin
                        rx_baud <= HALF_M1;
                        rstate  <= R_START;
                    end
                end
                R_START: begin
                    if (rx_baud != '0) begin
                        rx_baud <= rx_baud - 1'b1;
                    end else if (!rx_sync) begin
                        rx_baud <= BAUD_M1;
                        rx_bits <= '0;
                        rdy_q   <= 1'b0;
                        rstate  <= R_DATA;
                    end else begin
                        rstate <= R_IDLE;
                    end
                end
                R_DATA: begin
                    if (rx_baud != '0) begin
                        rx_baud <= rx_baud - 1'b1;
                    end else begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_baud  <= BAUD_M1;
                        rx_bits  <= rx_bits + 1'b1;
                        if (rx_bits == 4'd7) rstate <= R_STOP;
                    end
                end
                default: begin
                    if (rx_baud != '0) begin
                        rx_baud <= rx_baud - 1'b1;
                    end else begin
                        if (rx_sync) begin
                            resp_q <= rx_shift;
                            rdy_q  <= 1'b1;
                        end
                        rstate <= R_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - self-checking bench for remote_comm against a frame-level reference model
module tb_remote_comm;
    localparam int B = 16;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic rx_drv;
    logic loopback;
    logic rx_line;

    int vectors = 0;
    int errs    = 0;

    logic [7:0] resp_m;
    logic       rdy_m;
    logic [7:0] got[$];

    remote_comm_if bus ();

    assign rx_line = loopback ? tx : rx_drv;

    remote_comm #(.BAUD_CNT(B)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus),
        .TX   (tx),
        .RX   (rx_line)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line level of wire bit k (0..19) of a two-frame 8N1 command, high byte first
    function automatic logic exp_bit(input logic [15:0] w, input int k);
        logic [7:0] b;
        int j;
        b = (k < 10) ? w[15:8] : w[7:0];
        j = k % 10;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic send_cmd(input logic [15:0] w, input logic inject, input logic [15:0] iw);
        logic prev;
        @(negedge clk);
        chk("tx_idle_pre", 16'(tx), 16'h1);
        bus.cmd     = w;
        bus.snd_cmd = 1'b1;
        @(negedge clk);
        bus.snd_cmd = 1'b0;
        bus.cmd     = 16'($urandom);
        prev        = 1'b0;
        for (int c = 0; c <= 20*B + B + B/2; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.resp_rdy && !prev) got.push_back(bus.resp);
            prev = bus.resp_rdy;
            if (c == 0) begin
                chk("start_edge", 16'(tx), 16'h0);
                chk("rdy_clr_on_cmd", 16'(bus.resp_rdy), 16'h0);
                chk("cmd_snt_clr", 16'(bus.cmd_snt), 16'h0);
            end
            if (c < 20*B && (c % B) == B/2)
                chk($sformatf("tx_bit%0d", c / B), 16'(tx), 16'(exp_bit(w, c / B)));
            if (c == 20*B - 1) chk("cmd_snt_early", 16'(bus.cmd_snt), 16'h0);
            if (c == 20*B)     chk("cmd_snt_set", 16'(bus.cmd_snt), 16'h1);
            if (c > 20*B && (c % B) == B/2) chk("tx_idle_post", 16'(tx), 16'h1);
            if (inject) begin
                if (c == 100) begin
                    bus.cmd     = iw;
                    bus.snd_cmd = 1'b1;
                end else if (c == 101) begin
                    bus.snd_cmd = 1'b0;
                end
            end
        end
        rdy_m = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int c = 0; c < 10*B; c++) begin
            @(negedge clk);
            if (c == 9*B + B/2 && stop)
                chk("rdy_not_early", 16'(bus.resp_rdy), 16'h0);
            if (c == 9*B + B/2 + 3) begin
                if (stop) begin
                    resp_m = b;
                    rdy_m  = 1'b1;
                end else begin
                    rdy_m  = 1'b0;
                end
                chk("rx_rdy", 16'(bus.resp_rdy), 16'(rdy_m));
                chk("rx_resp", 16'(bus.resp), 16'(resp_m));
            end
            rx_drv = fr[c / B];
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (2*B) @(negedge clk);
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  rb;
        logic [7:0]  g0;
        logic [7:0]  g1;

        rst = 1'b1; bus.cmd = '0; bus.snd_cmd = 1'b0; rx_drv = 1'b1; loopback = 1'b0;
        resp_m = 8'h00; rdy_m = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", 16'(tx), 16'h1);
        chk("rst_cmd_snt", 16'(bus.cmd_snt), 16'h0);
        chk("rst_rdy", 16'(bus.resp_rdy), 16'h0);
        chk("rst_resp", 16'(bus.resp), 16'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send_cmd(16'h2000, 1'b0, 16'h0000);
        send_cmd(16'($urandom), 1'b1, 16'hA5C3);
        for (int i = 0; i < 2; i++) send_cmd(16'($urandom), 1'b0, 16'h0000);
        chk("no_rx_during_tx", 16'(got.size()), 16'h0);

        drive_rx(8'hA5, 1'b1);
        chk("rdy_holds", 16'(bus.resp_rdy), 16'h1);
        send_cmd(16'($urandom), 1'b0, 16'h0000);

        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3*B) @(negedge clk);
        chk("glitch_rdy", 16'(bus.resp_rdy), 16'(rdy_m));
        chk("glitch_resp", 16'(bus.resp), 16'(resp_m));

        drive_rx(8'h3C, 1'b0);
        chk("frame_err_resp", 16'(bus.resp), 16'(resp_m));
        rb = 8'($urandom_range(0, 255));
        drive_rx(rb, 1'b1);

        loopback = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? 16'h1234 : 16'($urandom);
            got.delete();
            send_cmd(w, 1'b0, 16'h0000);
            g0 = (got.size() > 0) ? got[0] : 8'hxx;
            g1 = (got.size() > 1) ? got[1] : 8'hxx;
            chk("loop_count", 16'(got.size()), 16'h2);
            chk("loop_hi", 16'(g0), 16'(w[15:8]));
            chk("loop_lo", 16'(g1), 16'(w[7:0]));
            chk("loop_rdy", 16'(bus.resp_rdy), 16'h1);
            chk("loop_cmd_snt", 16'(bus.cmd_snt), 16'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
